// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: one requester port of the data-memory arbiter.
//
// Handshake: the requester raises req with we/funct3/addr/wdata stable and
// holds them until ack. ack is a one-cycle pulse; err and rdata are valid
// only while ack is high and read as zero otherwise. A req still high in the
// cycle after ack is taken as a new request.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 6
);
    logic              req;
    logic              we;
    logic [2:0]        funct3;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic              ack;
    logic              err;
    logic [31:0]       rdata;

    modport master (
        output req, we, funct3, addr, wdata,
        input  ack, err, rdata
    );

    modport slave (
        input  req, we, funct3, addr, wdata,
        output ack, err, rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port (A = CPU, B = secondary master) arbiter and access
// sequencer for the byte-addressable data memory. Each access walks
// IDLE -> ACCESS -> DONE; illegal accesses are rejected at arbitration and
// pass through ACCESS with both memory strobes low.
//
// Build option: define DMEM_ARB_FIXED_PRIO_EN to give port A fixed priority
// on simultaneous requests (round-robin pointer removed). Default build is
// round-robin.
module dmem_arbiter #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    dmem_arbiter_if.slave     a,
    dmem_arbiter_if.slave     b,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [2:0]        mem_funct3,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              busy,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;

    logic              win_b_q;     // served port: 0 = A, 1 = B
    logic              err_q;       // served access was rejected
    logic [31:0]       rdata_q;     // load result for the served port

    logic              a_eff;
    logic              b_eff;
    logic              grant_b;
    logic              load_grant;
    logic              sel_we;
    logic [2:0]        sel_f3;
    logic [ADDR_W-1:0] sel_addr;
    logic [31:0]       sel_wdata;
    logic              sel_illegal;
    logic              done_a;
    logic              done_b;

`ifndef DMEM_ARB_FIXED_PRIO_EN
    logic              last_b_q;    // last served port: 0 = A, 1 = B
`endif

    // Access legality: bad width code, store with unsigned code, misaligned
    // half/word, or an access whose last byte would fall past the top of
    // memory (so nothing ever wraps to address 0).
    function automatic logic illegal_f(input logic              we,
                                       input logic [2:0]        f3,
                                       input logic [ADDR_W-1:0] addr);
        logic            bad;
        logic [ADDR_W:0] size;
        logic [ADDR_W:0] end_x;
        bad  = 1'b0;
        size = (ADDR_W+1)'(1);
        case (f3)
            3'b000, 3'b100: size = (ADDR_W+1)'(1);
            3'b001, 3'b101: size = (ADDR_W+1)'(2);
            3'b010:         size = (ADDR_W+1)'(4);
            default:        bad  = 1'b1;
        endcase
        if (we && f3[2])
            bad = 1'b1;
        if ((f3[1:0] == 2'b01) && addr[0])
            bad = 1'b1;
        if ((f3[1:0] == 2'b10) && (addr[1:0] != 2'b00))
            bad = 1'b1;
        end_x = {1'b0, addr} + size;
        if (end_x > {1'b1, {ADDR_W{1'b0}}})
            bad = 1'b1;
        return bad;
    endfunction

    // Arbitration, request selection and FSM next state.
    always_comb begin
        // The port being acked in DONE still holds req; mask it for this cycle.
        a_eff = a.req && !((state_q == DONE) && !win_b_q);
        b_eff = b.req && !((state_q == DONE) && win_b_q);
`ifdef DMEM_ARB_FIXED_PRIO_EN
        grant_b = b_eff && !a_eff;
`else
        grant_b = b_eff && (!a_eff || !last_b_q);
`endif
        load_grant  = ((state_q == IDLE) || (state_q == DONE)) && (a_eff || b_eff);
        sel_we      = grant_b ? b.we     : a.we;
        sel_f3      = grant_b ? b.funct3 : a.funct3;
        sel_addr    = grant_b ? b.addr   : a.addr;
        sel_wdata   = grant_b ? b.wdata  : a.wdata;
        sel_illegal = illegal_f(sel_we, sel_f3, sel_addr);

        state_d = state_q;
        case (state_q)
            IDLE:    if (a_eff || b_eff) state_d = ACCESS;
            ACCESS:  state_d = DONE;
            DONE:    state_d = (a_eff || b_eff) ? ACCESS : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Winner, memory-side registers and load-result capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_b_q    <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            mem_addr   <= '0;
            mem_funct3 <= '0;
            mem_wdata  <= '0;
        end else if (load_grant) begin
            win_b_q    <= grant_b;
            err_q      <= sel_illegal;
            mem_read   <= !sel_illegal && !sel_we;
            mem_write  <= !sel_illegal && sel_we;
            mem_addr   <= sel_addr;
            mem_funct3 <= sel_f3;
            mem_wdata  <= sel_wdata;
        end else if (state_q == ACCESS) begin
            // Strobes last exactly the ACCESS cycle; stores and rejected
            // accesses return zero.
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            rdata_q   <= mem_read ? mem_rdata : 32'h0;
        end
    end

`ifndef DMEM_ARB_FIXED_PRIO_EN
    // Round-robin pointer: remembers the last granted port; resets to B so
    // that A wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last_b_q <= 1'b1;
        else if (load_grant)
            last_b_q <= grant_b;
    end
`endif

    assign done_a = (state_q == DONE) && !win_b_q;
    assign done_b = (state_q == DONE) && win_b_q;

    assign a.ack   = done_a;
    assign a.err   = done_a && err_q;
    assign a.rdata = done_a ? rdata_q : 32'h0;
    assign b.ack   = done_b;
    assign b.err   = done_b && err_q;
    assign b.rdata = done_b ? rdata_q : 32'h0;

    assign busy      = (state_q != IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed bench for dmem_arbiter with a width-aware
// byte memory model, an expected-response queue and an ack monitor.
module tb_dmem_arbiter;
    localparam int ADDR_W = 6;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(ADDR_W)) a_if ();
    dmem_arbiter_if #(.ADDR_W(ADDR_W)) b_if ();

    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [2:0]        mem_funct3;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              busy;
    logic [1:0]        dbg_state;

    dmem_arbiter #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .a          (a_if),
        .b          (b_if),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_funct3 (mem_funct3),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .busy       (busy),
        .dbg_state  (dbg_state)
    );

    // ---------------- memory model ----------------
    logic [7:0] mem [64];
    logic [7:0] by0, by1, by2, by3;

    always_comb begin
        by0 = mem[mem_addr];
        by1 = mem[mem_addr + 6'd1];
        by2 = mem[mem_addr + 6'd2];
        by3 = mem[mem_addr + 6'd3];
        mem_rdata = 32'hDEADBEEF;
        if (mem_read) begin
            case (mem_funct3)
                3'b000:  mem_rdata = {{24{by0[7]}}, by0};
                3'b100:  mem_rdata = {24'h0, by0};
                3'b001:  mem_rdata = {{16{by1[7]}}, by1, by0};
                3'b101:  mem_rdata = {16'h0, by1, by0};
                3'b010:  mem_rdata = {by3, by2, by1, by0};
                default: mem_rdata = 32'hDEADBEEF;
            endcase
        end
    end

    always @(posedge clk) begin
        if (mem_write) begin
            mem[mem_addr] <= mem_wdata[7:0];
            if (mem_funct3[1:0] != 2'b00)
                mem[mem_addr + 6'd1] <= mem_wdata[15:8];
            if (mem_funct3[1:0] == 2'b10) begin
                mem[mem_addr + 6'd2] <= mem_wdata[23:16];
                mem[mem_addr + 6'd3] <= mem_wdata[31:24];
            end
        end
    end

    // ---------------- scoreboard ----------------
    int          total = 0;
    int          bad = 0;
    logic [33:0] exp_q[$];          // {port_b, err, rdata}
    logic        chk_no_strobe = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    // Monitor: pops one expectation per ack and checks quiet outputs.
    initial begin : monitor
        logic [33:0] e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (a_if.ack || b_if.ack) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_ack: got a=%b b=%b want none", a_if.ack, b_if.ack);
                    end else begin
                        e = exp_q.pop_front();
                        chk("ack_port", {30'h0, a_if.ack, b_if.ack}, e[33] ? 32'd1 : 32'd2);
                        chk("ack_err", {31'h0, e[33] ? b_if.err : a_if.err}, {31'h0, e[32]});
                        chk("ack_rdata", e[33] ? b_if.rdata : a_if.rdata, e[31:0]);
                    end
                end
                if (!a_if.ack) chk("a_quiet", {a_if.err, a_if.rdata[30:0]} | {31'h0, a_if.rdata[31]}, 32'h0);
                if (!b_if.ack) chk("b_quiet", {b_if.err, b_if.rdata[30:0]} | {31'h0, b_if.rdata[31]}, 32'h0);
                if (chk_no_strobe) chk("no_strobe", {30'h0, mem_read, mem_write}, 32'h0);
            end
        end
    end

    // ---------------- driver ----------------
    // Called at a negedge with the DUT idle; returns at a negedge, idle again.
    task automatic access(input bit port_b, input logic we, input logic [2:0] f3,
                          input logic [5:0] addr, input logic [31:0] wd,
                          input logic exp_err, input logic [31:0] exp_rd,
                          input string name);
        int n;
        bit got;
        exp_q.push_back({port_b, exp_err, exp_rd});
        if (port_b) begin
            b_if.req = 1'b1; b_if.we = we; b_if.funct3 = f3; b_if.addr = addr; b_if.wdata = wd;
        end else begin
            a_if.req = 1'b1; a_if.we = we; a_if.funct3 = f3; a_if.addr = addr; a_if.wdata = wd;
        end
        n = 0;
        got = 1'b0;
        while (!got && n < 20) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            got = port_b ? b_if.ack : a_if.ack;
        end
        chk({name, "_latency"}, 32'(n), 32'd2);
        a_if.req = 1'b0;
        b_if.req = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 8'h00;
        a_if.req = 1'b0; a_if.we = 1'b0; a_if.funct3 = 3'b000; a_if.addr = '0; a_if.wdata = '0;
        b_if.req = 1'b0; b_if.we = 1'b0; b_if.funct3 = 3'b000; b_if.addr = '0; b_if.wdata = '0;

        // Reset values.
        repeat (2) @(negedge clk);
        chk("rst_state", {30'h0, dbg_state}, 32'd0);
        chk("rst_busy", {31'h0, busy}, 32'd0);
        chk("rst_strobes", {30'h0, mem_read, mem_write}, 32'd0);
        chk("rst_mem_addr", {26'h0, mem_addr}, 32'd0);
        chk("rst_mem_funct3", {29'h0, mem_funct3}, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_acks", {28'h0, a_if.ack, a_if.err, b_if.ack, b_if.err}, 32'd0);
        chk("rst_a_rdata", a_if.rdata, 32'd0);
        chk("rst_b_rdata", b_if.rdata, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic store / load round trip.
        access(1'b0, 1'b1, 3'b010, 6'd4, 32'h11223344, 1'b0, 32'h0, "a_sw4");
        access(1'b0, 1'b0, 3'b010, 6'd4, 32'h0, 1'b0, 32'h11223344, "a_lw4");

        // Byte/half loads with sign and zero extension.
        access(1'b1, 1'b1, 3'b000, 6'd0, 32'hFFFFFF91, 1'b0, 32'h0, "b_sb0");
        access(1'b1, 1'b1, 3'b000, 6'd1, 32'h00000009, 1'b0, 32'h0, "b_sb1");
        access(1'b0, 1'b0, 3'b000, 6'd0, 32'h0, 1'b0, 32'hFFFFFF91, "a_lb0");
        access(1'b0, 1'b0, 3'b100, 6'd0, 32'h0, 1'b0, 32'h00000091, "a_lbu0");
        access(1'b0, 1'b0, 3'b001, 6'd0, 32'h0, 1'b0, 32'h00000991, "a_lh0");

        // Top-of-memory accesses that just fit.
        access(1'b0, 1'b1, 3'b001, 6'd62, 32'h0000BEEF, 1'b0, 32'h0, "a_sh62");
        access(1'b1, 1'b0, 3'b101, 6'd62, 32'h0, 1'b0, 32'h0000BEEF, "b_lhu62");
        access(1'b1, 1'b0, 3'b001, 6'd62, 32'h0, 1'b0, 32'hFFFFBEEF, "b_lh62");
        access(1'b0, 1'b0, 3'b010, 6'd60, 32'h0, 1'b0, 32'hBEEF0000, "a_lw60");
        access(1'b0, 1'b0, 3'b100, 6'd63, 32'h0, 1'b0, 32'h000000BE, "a_lbu63");

        // Rejected accesses: err with zero data, memory never strobed.
        chk_no_strobe = 1'b1;
        access(1'b1, 1'b0, 3'b010, 6'd2, 32'h0, 1'b1, 32'h0, "b_lw2_misalign");
        access(1'b1, 1'b1, 3'b001, 6'd63, 32'h00001234, 1'b1, 32'h0, "b_sh63_wrap");
        access(1'b1, 1'b1, 3'b100, 6'd10, 32'h000000AA, 1'b1, 32'h0, "b_st_f3_100");
        access(1'b0, 1'b0, 3'b011, 6'd8, 32'h0, 1'b1, 32'h0, "a_f3_011");
        access(1'b1, 1'b0, 3'b110, 6'd0, 32'h0, 1'b1, 32'h0, "b_f3_110");
        access(1'b0, 1'b0, 3'b010, 6'd61, 32'h0, 1'b1, 32'h0, "a_lw61");
        chk_no_strobe = 1'b0;
        access(1'b0, 1'b0, 3'b010, 6'd0, 32'h0, 1'b0, 32'h00000991, "a_lw0_intact");
        access(1'b1, 1'b0, 3'b100, 6'd10, 32'h0, 1'b0, 32'h00000000, "b_lbu10_intact");

        // Contention: both ports hold req; grants alternate A, B, A, B.
        exp_q.push_back({1'b0, 1'b0, 32'h11223344});
        exp_q.push_back({1'b1, 1'b0, 32'hBEEF0000});
        exp_q.push_back({1'b0, 1'b0, 32'h11223344});
        exp_q.push_back({1'b1, 1'b0, 32'hBEEF0000});
        a_if.req = 1'b1; a_if.we = 1'b0; a_if.funct3 = 3'b010; a_if.addr = 6'd4;
        b_if.req = 1'b1; b_if.we = 1'b0; b_if.funct3 = 3'b010; b_if.addr = 6'd60;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(posedge clk);
            @(negedge clk);
            chk("contend_busy", {31'h0, busy}, 32'd1);
            chk("contend_acks", {30'h0, a_if.ack, b_if.ack},
                (cyc % 4 == 2) ? 32'd2 : ((cyc % 4 == 0) ? 32'd1 : 32'd0));
        end
        a_if.req = 1'b0;
        b_if.req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("contend_end_busy", {31'h0, busy}, 32'd0);
        chk("contend_end_state", {30'h0, dbg_state}, 32'd0);

        // Reset in the middle of an A store.
        a_if.req = 1'b1; a_if.we = 1'b1; a_if.funct3 = 3'b010; a_if.addr = 6'd8; a_if.wdata = 32'hCAFEBABE;
        @(posedge clk);
        #1;
        chk("rst_mid_access_state", {30'h0, dbg_state}, 32'd1);
        chk("rst_mid_mem_write", {31'h0, mem_write}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_strobes", {30'h0, mem_read, mem_write}, 32'd0);
        chk("rst_mid_busy", {31'h0, busy}, 32'd0);
        a_if.req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_mid_no_ack", {31'h0, a_if.ack}, 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_mid_idle", {30'h0, dbg_state}, 32'd0);
        access(1'b0, 1'b1, 3'b010, 6'd8, 32'hCAFEBABE, 1'b0, 32'h0, "a_sw8_reissue");
        access(1'b0, 1'b0, 3'b010, 6'd8, 32'h0, 1'b0, 32'hCAFEBABE, "a_lw8");

        // Drain the expected queue (bounded).
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and access sequencer for the byte-addressable data memory. It sits between the CPU load/store port (A) and a secondary master such as a DMA or debug loader (B), and drives the memory's single read/write port. Each access is serialized through a small FSM with a request/acknowledge handshake. Illegal accesses are rejected before they reach the memory, and an error flag is returned with the acknowledge.

## Interface
- ADDR_W, 6, byte-address width; memory spans 2^ADDR_W bytes
- clk  in  1  clock; all state changes on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- a_req, b_req  in  1  request; held high with stable fields until the matching ack
- a_we, b_we  in  1  1 = store, 0 = load
- a_funct3, b_funct3  in  3  RV32 width code: 000 b, 001 h, 010 w, 100 bu, 101 hu
- a_addr, b_addr  in  ADDR_W  byte address
- a_wdata, b_wdata  in  32  store data, right-aligned
- a_ack, b_ack  out  1  one-cycle completion pulse
- a_err, b_err  out  1  valid with ack; 1 = access rejected
- a_rdata, b_rdata  out  32  load result, valid with ack
- mem_read, mem_write  out  1  memory strobes (registered)
- mem_addr  out  ADDR_W  memory address (registered)
- mem_funct3  out  3  memory width code (registered)
- mem_wdata  out  32  memory store data (registered)
- mem_rdata  in  32  combinational memory read data
- busy  out  1  high whenever FSM is not IDLE

## Operation
- FSM states:
  - IDLE: no access in progress.
  - ACCESS: memory strobes are driven for one cycle.
  - DONE: the served requester receives ack, err and rdata for one cycle.
- IDLE: if any req is high, arbitrate, register the winner and its mem_* fields, then go to ACCESS. If no req is high, stay in IDLE.
- ACCESS: always lasts exactly 1 cycle, then goes to DONE.
  - Loads: latch mem_rdata into the winner's rdata register at the ACCESS→DONE edge.
  - Stores: the memory commits at that same edge.
- DONE: pulse the winner's ack, with err and rdata. In the same cycle, arbitrate again with the served port's req masked, because that requester has not yet dropped req.
  - Other port requesting: go directly to ACCESS (back-to-back).
  - Otherwise: go to IDLE.
- Arbitration: round-robin. The last-served pointer favours the other port on a tie.
- Legality check, done at arbitration. err = 1 if any of:
  - funct3 is 011, 110 or 111
  - store with funct3 100 or 101
  - halfword with addr[0] = 1
  - word with addr[1:0] ≠ 0
  - addr + access size exceeds 2^ADDR_W, so no wrap-around access is ever issued
- Illegal request still passes through ACCESS, with mem_read = mem_write = 0 and rdata = 0. Timing stays uniform.
- Stores return rdata = 0.
- Non-served port's ack, err and rdata stay 0.
- mem_read and mem_write are deasserted in every state except ACCESS.

## Timing
- Reset values (asynchronous):
  - FSM: IDLE
  - mem_read, mem_write: 0
  - mem_addr, mem_funct3, mem_wdata: 0
  - all ack, err and rdata outputs: 0
  - busy: 0
  - round-robin pointer = B, so A wins the first tie
- Latency: req sampled high in IDLE at cycle N → ACCESS in N+1 → ack in N+2.
- Throughput under contention: one access per 2 cycles (ACCESS, DONE, ACCESS…).
- Requester must deassert req the cycle after ack, or present a new request. A req still high in the cycle after ack is a new request.
- Reset asserted during ACCESS:
  - strobes clear immediately
  - no ack is issued
  - the write may or may not commit, depending on the edge; the requester must reissue
- A req that rises during ACCESS or DONE waits; it is never dropped.

## Configuration
- DMEM_ARB_FIXED_PRIO_EN
  - Defined: port A always wins a simultaneous request, and the round-robin pointer is removed. The DONE-state mask still applies, so B is served whenever A is masked.
  - Undefined: round-robin as described above.

## Test plan
- Reset then A store word 0x11223344 @ addr 4 → a_ack at N+2, a_err = 0; then A load word @ 4 → a_rdata = 0x11223344.
- A and B request in the same cycle after reset, both holding req → grant order A, B, A, B. Acks two cycles apart; busy stays high. With DMEM_ARB_FIXED_PRIO_EN, A is still served whenever A is unmasked.
- Memory byte @ 0 = 0x91, A lb @ 0 → rdata 0xFFFFFF91; lbu @ 0 → 0x00000091; lh @ 0 with byte @ 1 = 0x09 → 0x00000991.
- Illegal accesses, each → ack with err = 1, rdata = 0, and mem_read = mem_write = 0 throughout:
  - B lw @ 2 (misaligned)
  - B sh @ 63 (would wrap)
  - B store funct3 100
- rst_n pulled low during ACCESS of an A store → mem_write drops asynchronously; no a_ack; FSM in IDLE after release; a reissued request completes normally.
